// File: rtl/ras_spill_mem_resp.sv
// ras_spill_mem_resp
// Memory-side responder for the return-address-stack spill port. The CRAS
// controller spills encrypted frames with ascending writes and refills them
// with descending reads. The responder keeps the words in an internal array,
// tracks the LIFO top, checks address range and handshake rules, and reports
// occupancy plus sticky error flags for the MMIO block.
//
// Ports
//   clk         system clock, all state on the rising edge
//   rst         asynchronous, active-high reset
//   mem_rd      read request, taken only while mem_rdy=1
//   mem_wr      write request, taken only while mem_rdy=1
//   mem_addr    byte address, word aligned; word index = mem_addr[31:2]
//   mem_din     write data
//   mem_rdy     responder can accept a request this cycle
//   mem_dout    read data, held until the next read completes
//   mem_dvalid  one-cycle pulse when mem_dout was updated
//   words_used  LIFO top pointer = number of spilled words held
//   err         sticky {proto, lifo, range}
//   err_clr     synchronous clear of err; an error raised in the same cycle wins
//
// Parameters
//   W       data word width
//   DEPTH   backing store size in words, power of 2, 4 .. 2**29
//   RD_LAT  cycles from read accept edge to mem_dout/mem_dvalid, 1..4
//   WR_LAT  write occupancy; mem_rdy stays low WR_LAT-1 cycles after a write, 1..8

module ras_spill_mem_resp #(
  parameter int W      = 32,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 1,
  parameter int WR_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_rd,
  input  logic                     mem_wr,
  input  logic [31:0]              mem_addr,
  input  logic [W-1:0]             mem_din,
  output logic                     mem_rdy,
  output logic [W-1:0]             mem_dout,
  output logic                     mem_dvalid,
  output logic [$clog2(DEPTH):0]   words_used,
  output logic [2:0]               err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  typedef enum logic {
    IDLE    = 1'b0,
    WR_BUSY = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [PW-1:0]  top, top_nxt;
  logic [2:0]     err_nxt;

  // Address decode: anything above the array or not word aligned is a range error.
  logic [AW-1:0]  idx;
  logic [PW-1:0]  idx_ext;
  logic           addr_ok;

  assign idx     = mem_addr[AW+1:2];
  assign idx_ext = {1'b0, idx};
  assign addr_ok = (mem_addr[1:0] == 2'b00) && (mem_addr[31:AW+2] == '0);

  // Request classification
  logic accept;
  logic wr_acc, rd_acc;
  logic wr_ok, rd_ok;
  logic wr_lifo, rd_lifo;
  logic ev_proto, ev_lifo, ev_range;

  always_comb begin
    accept   = (state == IDLE);
    wr_acc   = accept & mem_wr;
    // A simultaneous read and write performs only the write.
    rd_acc   = accept & mem_rd & ~mem_wr;
    // A full stack has no slot at index DEPTH, so that write counts as out of range.
    wr_ok    = wr_acc & addr_ok & (top != FULL);
    rd_ok    = rd_acc & addr_ok;
    // Out-of-order accesses still move data but leave the pointer alone.
    wr_lifo  = wr_ok & (idx_ext != top);
    rd_lifo  = rd_ok & ((top == '0) | (idx_ext != (top - PW'(1))));
    ev_proto = (~accept & (mem_rd | mem_wr)) | (accept & mem_rd & mem_wr);
    ev_range = (wr_acc & ~(addr_ok & (top != FULL))) | (rd_acc & ~addr_ok);
    ev_lifo  = wr_lifo | rd_lifo;
  end

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (wr_acc && (WR_LAT > 1)) begin
          state_nxt = WR_BUSY;
          cnt_nxt   = CW'(WR_LAT - 1);
        end
      end
      WR_BUSY: begin
        if (cnt == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    top_nxt = top;
    if (wr_ok && !wr_lifo) begin
      top_nxt = top + PW'(1);
    end else if (rd_ok && !rd_lifo) begin
      top_nxt = top - PW'(1);
    end
  end

  // Clear first, then OR in this cycle's events, so a new error survives err_clr.
  always_comb begin
    err_nxt = err_clr ? 3'b000 : err;
    err_nxt = err_nxt | {ev_proto, ev_lifo, ev_range};
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      top   <= '0;
      err   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      top   <= top_nxt;
      err   <= err_nxt;
    end
  end

  assign mem_rdy    = (state == IDLE);
  assign words_used = top;

  // Backing store
  // NOTE: the array has no reset; its contents survive rst, and leaving it out
  // of the reset network lets it map onto RAM.
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[idx] <= mem_din;
    end
  end

  // Out-of-range reads return zero but still travel the pipe so the requester
  // sees a dvalid for every read it issued.
  assign rd_word = rd_ok ? mem[idx] : '0;

  // Read pipe: stage 0 captures the word at the accept edge, the last stage is
  // the visible mem_dout. Each stage only loads when valid data arrives, so the
  // last stage holds its value between reads.
  logic [RD_LAT-1:0] pipe_v;
  logic [W-1:0]      pipe_d [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_d[k] <= '0;
      end
    end else begin
      pipe_v[0] <= rd_acc;
      if (rd_acc) begin
        pipe_d[0] <= rd_word;
      end
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        if (pipe_v[k-1]) begin
          pipe_d[k] <= pipe_d[k-1];
        end
      end
    end
  end

  assign mem_dvalid = pipe_v[RD_LAT-1];
  assign mem_dout   = pipe_d[RD_LAT-1];

endmodule

// File: tb/tb_ras_spill_mem_resp.sv
module tb_ras_spill_mem_resp;

  localparam int D3   = 16;
  localparam int RL3  = 3;
  localparam int WL3  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: default parameters (W=32, DEPTH=256, RD_LAT=1, WR_LAT=1)
  logic        rst1 = 1'b1, rd1 = 1'b0, wr1 = 1'b0, clr1 = 1'b0;
  logic [31:0] addr1 = '0, din1 = '0;
  logic        rdy1, dv1;
  logic [31:0] dout1;
  logic [8:0]  used1;
  logic [2:0]  err1;

  ras_spill_mem_resp dut1 (
    .clk(clk), .rst(rst1), .mem_rd(rd1), .mem_wr(wr1), .mem_addr(addr1),
    .mem_din(din1), .mem_rdy(rdy1), .mem_dout(dout1), .mem_dvalid(dv1),
    .words_used(used1), .err(err1), .err_clr(clr1)
  );

  // Instance 3: small store, multi-cycle read and write latency
  logic        rst3 = 1'b1, rd3 = 1'b0, wr3 = 1'b0, clr3 = 1'b0;
  logic [31:0] addr3 = '0, din3 = '0;
  logic        rdy3, dv3;
  logic [31:0] dout3;
  logic [4:0]  used3;
  logic [2:0]  err3;

  ras_spill_mem_resp #(.W(32), .DEPTH(D3), .RD_LAT(RL3), .WR_LAT(WL3)) dut3 (
    .clk(clk), .rst(rst3), .mem_rd(rd3), .mem_wr(wr3), .mem_addr(addr3),
    .mem_din(din3), .mem_rdy(rdy3), .mem_dout(dout3), .mem_dvalid(dv3),
    .words_used(used3), .err(err3), .err_clr(clr3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Table vectors for instance 1: inputs for one cycle, outputs expected after the edge
  typedef struct {
    logic        rd, wr, clr;
    logic [31:0] addr, din;
    logic        rdy, dv;
    logic [31:0] dout;
    logic [8:0]  used;
    logic [2:0]  err;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic clr,
                              input logic [31:0] addr, input logic [31:0] din,
                              input logic dv, input logic [31:0] dout,
                              input logic [8:0] used, input logic [2:0] err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.clr = clr; v.addr = addr; v.din = din;
    v.rdy = 1'b1; v.dv = dv; v.dout = dout; v.used = used; v.err = err;
    return v;
  endfunction

  vec_t vt [19];

  // Behavioural reference for instance 3
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } rd_t;

  logic [31:0] m_mem [D3];
  bit          m_known [D3];
  int          m_top, m_busy, m_cyc;
  logic [2:0]  m_err;
  logic [31:0] m_dout;
  bit          m_dout_known, m_dv;
  rd_t         m_q [$];

  task automatic model_reset();
    m_top = 0; m_busy = 0; m_cyc = 0; m_err = '0;
    m_dout = '0; m_dout_known = 1'b1; m_dv = 1'b0;
    m_q.delete();
  endtask

  // Advance the model over one clock edge using the inputs currently driven on instance 3
  task automatic model_step();
    logic [2:0] ev;
    int         idx;
    bit         al;
    rd_t        r;
    ev  = '0;
    idx = int'(addr3[31:2]);
    al  = (addr3[1:0] == 2'b00);
    if (m_busy > 0) begin
      if (rd3 || wr3) ev[2] = 1'b1;
      m_busy--;
    end else if (wr3) begin
      if (rd3) ev[2] = 1'b1;
      if (!al || idx >= D3 || m_top >= D3) ev[0] = 1'b1;
      else begin
        m_mem[idx] = din3;
        m_known[idx] = 1'b1;
        if (idx == m_top) m_top++;
        else ev[1] = 1'b1;
      end
      m_busy = WL3 - 1;
    end else if (rd3) begin
      r.due = m_cyc + RL3;
      if (!al || idx >= D3) begin
        ev[0] = 1'b1; r.data = '0; r.known = 1'b1;
      end else begin
        r.data = m_mem[idx]; r.known = m_known[idx];
        if (m_top == 0 || idx != m_top - 1) ev[1] = 1'b1;
        else m_top--;
      end
      m_q.push_back(r);
    end
    m_err = (clr3 ? 3'b000 : m_err) | ev;
    m_cyc++;
    m_dv = 1'b0;
    if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
      m_dv = 1'b1;
      m_dout = m_q[0].data;
      m_dout_known = m_q[0].known;
      void'(m_q.pop_front());
    end
  endtask

  task automatic reset3_check(input string tag);
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    check({tag, " rdy"},  64'(rdy3),  64'd1);
    check({tag, " dv"},   64'(dv3),   64'd0);
    check({tag, " dout"}, 64'(dout3), 64'd0);
    check({tag, " used"}, 64'(used3), 64'd0);
    check({tag, " err"},  64'(err3),  64'd0);
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
  endtask

  initial begin
    int word, p, dv_seen;

    for (int i = 0; i < D3; i++) m_known[i] = 1'b0;

    // Reset state, both instances
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst1 rdy",  64'(rdy1),  64'd1);
    check("rst1 dv",   64'(dv1),   64'd0);
    check("rst1 dout", 64'(dout1), 64'd0);
    check("rst1 used", 64'(used1), 64'd0);
    check("rst1 err",  64'(err1),  64'd0);
    check("rst3 rdy",  64'(rdy3),  64'd1);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Spill/refill table on instance 1
    //          rd   wr   clr  addr        din           dv   dout          used err
    vt[0]  = mk(1'b0,1'b1,1'b0,32'h0,      32'h11,       1'b0,32'h0,        9'd1,3'b000);
    vt[1]  = mk(1'b0,1'b1,1'b0,32'h4,      32'h22,       1'b0,32'h0,        9'd2,3'b000);
    vt[2]  = mk(1'b0,1'b1,1'b0,32'h8,      32'h33,       1'b0,32'h0,        9'd3,3'b000);
    vt[3]  = mk(1'b0,1'b1,1'b0,32'hc,      32'h44,       1'b0,32'h0,        9'd4,3'b000);
    vt[4]  = mk(1'b1,1'b0,1'b0,32'hc,      32'h0,        1'b1,32'h44,       9'd3,3'b000);
    vt[5]  = mk(1'b1,1'b0,1'b0,32'h8,      32'h0,        1'b1,32'h33,       9'd2,3'b000);
    vt[6]  = mk(1'b0,1'b0,1'b0,32'h0,      32'h0,        1'b0,32'h33,       9'd2,3'b000);
    vt[7]  = mk(1'b0,1'b1,1'b0,32'h402,    32'hdead,     1'b0,32'h33,       9'd2,3'b001);
    vt[8]  = mk(1'b0,1'b1,1'b0,32'h400,    32'hbeef,     1'b0,32'h33,       9'd2,3'b001);
    vt[9]  = mk(1'b0,1'b0,1'b1,32'h0,      32'h0,        1'b0,32'h33,       9'd2,3'b000);
    vt[10] = mk(1'b1,1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h11,       9'd2,3'b010);
    vt[11] = mk(1'b0,1'b0,1'b1,32'h0,      32'h0,        1'b0,32'h11,       9'd2,3'b000);
    vt[12] = mk(1'b1,1'b1,1'b0,32'h8,      32'h55,       1'b0,32'h11,       9'd3,3'b100);
    vt[13] = mk(1'b1,1'b0,1'b0,32'h8,      32'h0,        1'b1,32'h55,       9'd2,3'b100);
    vt[14] = mk(1'b1,1'b0,1'b1,32'h400,    32'h0,        1'b1,32'h0,        9'd2,3'b001);
    vt[15] = mk(1'b0,1'b0,1'b1,32'h0,      32'h0,        1'b0,32'h0,        9'd2,3'b000);
    vt[16] = mk(1'b1,1'b0,1'b0,32'h4,      32'h0,        1'b1,32'h22,       9'd1,3'b000);
    vt[17] = mk(1'b1,1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h11,       9'd0,3'b000);
    vt[18] = mk(1'b1,1'b0,1'b0,32'h0,      32'h0,        1'b1,32'h11,       9'd0,3'b010);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      rd1 = vt[i].rd; wr1 = vt[i].wr; clr1 = vt[i].clr;
      addr1 = vt[i].addr; din1 = vt[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d rdy",  i), 64'(rdy1),  64'(vt[i].rdy));
      check($sformatf("vec%0d dv",   i), 64'(dv1),   64'(vt[i].dv));
      check($sformatf("vec%0d dout", i), 64'(dout1), 64'(vt[i].dout));
      check($sformatf("vec%0d used", i), 64'(used1), 64'(vt[i].used));
      check($sformatf("vec%0d err",  i), 64'(err1),  64'(vt[i].err));
    end
    @(negedge clk);
    rd1 = 1'b0; wr1 = 1'b0; clr1 = 1'b0;

    // WR_LAT=3 occupancy and a read held while busy
    @(negedge clk);
    wr3 = 1'b1; addr3 = 32'h0; din3 = 32'ha5;
    @(negedge clk);
    check("wbusy n+1 rdy", 64'(rdy3), 64'd0);
    wr3 = 1'b0; rd3 = 1'b1;
    @(negedge clk);
    check("wbusy n+2 rdy", 64'(rdy3), 64'd0);
    rd3 = 1'b0;
    @(negedge clk);
    check("wbusy n+3 rdy",  64'(rdy3),  64'd1);
    check("wbusy n+3 err",  64'(err3),  64'b100);
    check("wbusy n+3 used", 64'(used3), 64'd1);
    dv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (dv3) dv_seen++;
    end
    check("wbusy ignored rd no dvalid", 64'(dv_seen), 64'd0);

    // Randomised run against the reference model
    reset3_check("rst3a");
    model_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      check($sformatf("rnd%0d rdy", c),  64'(rdy3),  64'(m_busy == 0));
      check($sformatf("rnd%0d used", c), 64'(used3), 64'(m_top));
      check($sformatf("rnd%0d err", c),  64'(err3),  64'(m_err));
      check($sformatf("rnd%0d dv", c),   64'(dv3),   64'(m_dv));
      if (m_dout_known) check($sformatf("rnd%0d dout", c), 64'(dout3), 64'(m_dout));
      p = int'($urandom_range(0, 15));
      wr3 = (p <= 6) || (p == 13);
      rd3 = (p >= 7 && p <= 13);
      if ($urandom_range(0, 9) < 5) word = rd3 && !wr3 ? ((m_top > 0) ? m_top - 1 : 0) : m_top;
      else word = int'($urandom_range(0, D3 + 1));
      addr3 = 32'(word) << 2;
      if ($urandom_range(0, 15) == 0) addr3 = addr3 | 32'($urandom_range(1, 3));
      din3 = $urandom;
      clr3 = ($urandom_range(0, 15) == 0);
      model_step();
    end
    @(negedge clk);
    rd3 = 1'b0; wr3 = 1'b0; clr3 = 1'b0;

    // Reset during WR_BUSY with a read still in the pipe
    reset3_check("rst3b");
    rd3 = 1'b1; addr3 = 32'h0;
    @(negedge clk);
    rd3 = 1'b0; wr3 = 1'b1; din3 = 32'h77;
    @(negedge clk);
    wr3 = 1'b0;
    check("midflight busy", 64'(rdy3), 64'd0);
    rst3 = 1'b1;
    #1;
    check("midflight rst rdy",  64'(rdy3),  64'd1);
    check("midflight rst dv",   64'(dv3),   64'd0);
    check("midflight rst dout", 64'(dout3), 64'd0);
    check("midflight rst used", 64'(used3), 64'd0);
    check("midflight rst err",  64'(err3),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    dv_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dv3 || !rdy3) dv_seen++;
    end
    check("midflight no completion", 64'(dv_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
